joystick_sample_scheduler: RTL and testbench



---
 rtl/joystick_sample_scheduler.sv | 153 +++++++++++++++
 tb/tb_joystick_sample_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_sample_scheduler.sv
// Periodic MCP3008 sampling scheduler with conversion watchdog,
// box-car averaging of X/Y pairs and overrun/timeout accounting.
module joystick_sample_scheduler #(
  parameter int PERIOD_CYCLES  = 500000,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int AVG_LOG2       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       adc_start,
  input  logic [9:0] adc_x,
  input  logic [9:0] adc_y,
  input  logic       adc_valid,
  output logic [9:0] x_avg,
  output logic [9:0] y_avg,
  output logic       avg_valid,
  output logic       busy,
  output logic       timeout_pulse,
  output logic [7:0] overrun_cnt,
  output logic [7:0] timeout_cnt
);

  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = 10 + AVG_LOG2;
  localparam int IW = AVG_LOG2 + 1;

  localparam logic [PW-1:0] P_LAST =
    PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST =
    IW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    WAIT_TICK,
    PUBLISH
  } state_t;

  state_t state, nxt;

  logic [PW-1:0] pcnt;
  logic [TW-1:0] wd;
  logic [SW-1:0] sum_x, sum_y;
  logic [SW-1:0] nsum_x, nsum_y;
  logic [IW-1:0] idx;

  logic tick, accept, expire;
  logic keep, publish, drop;

  always_comb begin
    nxt     = state;
    tick    = 1'b0;
    accept  = 1'b0;
    expire  = 1'b0;
    keep    = 1'b0;
    publish = 1'b0;
    drop    = 1'b0;
    nsum_x  = sum_x + SW'(adc_x);
    nsum_y  = sum_y + SW'(adc_y);

    tick   = (state != IDLE) && (pcnt == P_LAST);
    accept = (state == WAIT_DATA) && adc_valid;
    expire = (state == WAIT_DATA) && !adc_valid
             && (wd == T_LAST);
    keep    = accept && enable;
    publish = keep && (idx == I_LAST);
    // A tick the FSM cannot act on is lost.
    drop = tick && ((state == WAIT_DATA)
                    || (state == PUBLISH));

    unique case (state)
      IDLE: if (enable) nxt = ISSUE;
      ISSUE: nxt = WAIT_DATA;
      WAIT_DATA: begin
        if (accept) begin
          if (!enable) nxt = IDLE;
          else if (publish) nxt = PUBLISH;
          else nxt = WAIT_TICK;
        end else if (expire) begin
          nxt = enable ? WAIT_TICK : IDLE;
        end
      end
      WAIT_TICK: begin
        if (!enable) nxt = IDLE;
        else if (tick) nxt = ISSUE;
      end
      PUBLISH: nxt = enable ? WAIT_TICK : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pcnt          <= '0;
      wd            <= '0;
      sum_x         <= '0;
      sum_y         <= '0;
      idx           <= '0;
      adc_start     <= 1'b0;
      x_avg         <= '0;
      y_avg         <= '0;
      avg_valid     <= 1'b0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      overrun_cnt   <= '0;
      timeout_cnt   <= '0;
    end else begin
      state <= nxt;

      // ISSUE counts as period cycle 0.
      if (state == IDLE) pcnt <= '0;
      else if (state == ISSUE) pcnt <= PW'(1);
      else if (tick) pcnt <= '0;
      else pcnt <= pcnt + PW'(1);

      if (state != WAIT_DATA) wd <= '0;
      else wd <= wd + TW'(1);

      if (state == IDLE || publish) begin
        sum_x <= '0;
        sum_y <= '0;
        idx   <= '0;
      end else if (keep) begin
        sum_x <= nsum_x;
        sum_y <= nsum_y;
        idx   <= idx + IW'(1);
      end

      if (publish) begin
        x_avg <= 10'(nsum_x >> AVG_LOG2);
        y_avg <= 10'(nsum_y >> AVG_LOG2);
      end

      adc_start     <= (state == ISSUE);
      avg_valid     <= publish;
      busy          <= (nxt == ISSUE)
                       || (nxt == WAIT_DATA);
      timeout_pulse <= expire;

      if (drop && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
      if (expire && timeout_cnt != 8'hFF)
        timeout_cnt <= timeout_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_joystick_sample_scheduler.sv
// Bench for joystick_sample_scheduler: two instances, a delayed
// driver model and a scoreboard of expected averaged pairs.
module tb_joystick_sample_scheduler;

  localparam int P  = 100;
  localparam int TA = 60;
  localparam int TB = 200;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
  } pair_t;

  typedef struct {
    int         dly;
    int         spc;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] ex;
    logic [9:0] ey;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en [2];
  logic       av [2] = '{1'b0, 1'b0};
  logic [9:0] ax [2] = '{10'd0, 10'd0};
  logic [9:0] ay [2] = '{10'd0, 10'd0};
  logic       start [2];
  logic       avv [2];
  logic       busy [2];
  logic       tp [2];
  logic [9:0] xa [2];
  logic [9:0] ya [2];
  logic [7:0] oc [2];
  logic [7:0] tc [2];

  joystick_sample_scheduler #(
    .PERIOD_CYCLES(P),
    .TIMEOUT_CYCLES(TA),
    .AVG_LOG2(2)
  ) u_a (
    .clk(clk), .rst(rst), .enable(en[0]),
    .adc_start(start[0]),
    .adc_x(ax[0]), .adc_y(ay[0]),
    .adc_valid(av[0]),
    .x_avg(xa[0]), .y_avg(ya[0]),
    .avg_valid(avv[0]), .busy(busy[0]),
    .timeout_pulse(tp[0]),
    .overrun_cnt(oc[0]), .timeout_cnt(tc[0])
  );

  joystick_sample_scheduler #(
    .PERIOD_CYCLES(P),
    .TIMEOUT_CYCLES(TB),
    .AVG_LOG2(0)
  ) u_b (
    .clk(clk), .rst(rst), .enable(en[1]),
    .adc_start(start[1]),
    .adc_x(ax[1]), .adc_y(ay[1]),
    .adc_valid(av[1]),
    .x_avg(xa[1]), .y_avg(ya[1]),
    .avg_valid(avv[1]), .busy(busy[1]),
    .timeout_pulse(tp[1]),
    .overrun_cnt(oc[1]), .timeout_cnt(tc[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int dly [2]        = '{40, 150};
  int spacing [2]    = '{0, 0};
  int tlen [2]       = '{TA, TB};
  int last_start [2] = '{-1, -1};
  int starts [2]     = '{0, 0};
  int tcount [2]     = '{0, 0};
  int vcyc [2]       = '{-10, -10};
  int pend [2]       = '{0, 0};
  int cnt [2]        = '{0, 0};

  pair_t smp0[$], smp1[$], exp0[$], exp1[$];

  task automatic check(input string name,
                       input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d",
               name, got, want);
    end
  endtask

  function automatic int ssize(input int g);
    return (g == 0) ? smp0.size() : smp1.size();
  endfunction

  function automatic int esize(input int g);
    return (g == 0) ? exp0.size() : exp1.size();
  endfunction

  task automatic push_s(input int g, input pair_t p);
    if (g == 0) smp0.push_back(p);
    else smp1.push_back(p);
  endtask

  task automatic push_e(input int g, input pair_t p);
    if (g == 0) exp0.push_back(p);
    else exp1.push_back(p);
  endtask

  task automatic pop_s(input int g, output pair_t p);
    if (g == 0) p = smp0.pop_front();
    else p = smp1.pop_front();
  endtask

  task automatic pop_e(input int g, output pair_t p);
    if (g == 0) p = exp0.pop_front();
    else p = exp1.pop_front();
  endtask

  // Monitor first (sees values of the cycle just sampled),
  // then the driver model updates adc_valid for the next edge.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pair_t p;
      if (start[g]) begin
        if (last_start[g] >= 0 && spacing[g] > 0)
          check($sformatf("spacing%0d", g),
                cyc - last_start[g], spacing[g]);
        last_start[g] = cyc;
        starts[g]++;
      end
      if (tp[g]) begin
        check($sformatf("tmo_lat%0d", g),
              cyc - last_start[g], tlen[g]);
        check($sformatf("busy_tmo%0d", g),
              int'(busy[g]), 0);
        tcount[g]++;
      end
      if (av[g])
        check($sformatf("busy_val%0d", g),
              int'(busy[g]), 0);
      if (avv[g]) begin
        check($sformatf("avg_expected%0d", g),
              int'(esize(g) > 0), 1);
        check($sformatf("avg_lat%0d", g),
              cyc, vcyc[g] + 1);
        if (esize(g) > 0) begin
          pop_e(g, p);
          check($sformatf("x_avg%0d", g),
                int'(xa[g]), int'(p.x));
          check($sformatf("y_avg%0d", g),
                int'(ya[g]), int'(p.y));
        end
      end
      av[g] = 1'b0;
      if (rst) begin
        pend[g] = 0;
      end else if (start[g]) begin
        pend[g] = 1;
        cnt[g]  = 0;
      end else if (pend[g] != 0) begin
        cnt[g]++;
        if (cnt[g] == dly[g]) begin
          pend[g] = 0;
          if (ssize(g) > 0) begin
            pop_s(g, p);
            av[g]   = 1'b1;
            ax[g]   = p.x;
            ay[g]   = p.y;
            vcyc[g] = cyc;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input int g, input int n,
                             input int bound);
    int tgt;
    int k;
    tgt = starts[g] + n;
    k = 0;
    while (starts[g] < tgt && k < bound) begin
      step(1);
      k++;
    end
    if (starts[g] < tgt)
      check($sformatf("wait_start%0d", g),
            starts[g], tgt);
  endtask

  task automatic wait_drain(input int g,
                            input int bound);
    int k;
    k = 0;
    while (esize(g) > 0 && k < bound) begin
      step(1);
      k++;
    end
    if (esize(g) > 0)
      check($sformatf("drain%0d", g), esize(g), 0);
  endtask

  task automatic wait_tmo(input int g, input int n,
                          input int bound);
    int tgt;
    int k;
    tgt = tcount[g] + n;
    k = 0;
    while (tcount[g] < tgt && k < bound) begin
      step(1);
      k++;
    end
    if (tcount[g] < tgt)
      check($sformatf("wait_tmo%0d", g),
            tcount[g], tgt);
  endtask

  task automatic enable_on(input int g);
    int c0;
    last_start[g] = -1;
    en[g] = 1'b1;
    c0 = cyc;
    wait_starts(g, 1, 10);
    check($sformatf("en_to_start%0d", g),
          last_start[g], c0 + 2);
  endtask

  task automatic check_rst(input int g,
                           input string t);
    check({t, "_start"}, int'(start[g]), 0);
    check({t, "_xavg"}, int'(xa[g]), 0);
    check({t, "_yavg"}, int'(ya[g]), 0);
    check({t, "_avgv"}, int'(avv[g]), 0);
    check({t, "_busy"}, int'(busy[g]), 0);
    check({t, "_tp"}, int'(tp[g]), 0);
    check({t, "_ovr"}, int'(oc[g]), 0);
    check({t, "_tcnt"}, int'(tc[g]), 0);
  endtask

  vec_t tbl [8];

  initial begin
    int sc;
    int oc0;
    pair_t p;

    tbl[0] = '{150, 200, 10'd517,  10'd3,
               10'd517,  10'd3};
    tbl[1] = '{150, 200, 10'd0,    10'd1023,
               10'd0,    10'd1023};
    tbl[2] = '{150, 200, 10'd1023, 10'd0,
               10'd1023, 10'd0};
    tbl[3] = '{150, 200, 10'd512,  10'd511,
               10'd512,  10'd511};
    tbl[4] = '{40,  100, 10'd517,  10'd3,
               10'd517,  10'd3};
    tbl[5] = '{40,  100, 10'd1,    10'd2,
               10'd1,    10'd2};
    tbl[6] = '{40,  100, 10'd700,  10'd300,
               10'd700,  10'd300};
    tbl[7] = '{40,  100, 10'd517,  10'd3,
               10'd517,  10'd3};

    en[0] = 1'b0;
    en[1] = 1'b0;
    step(3);
    check_rst(0, "rst_a");
    check_rst(1, "rst_b");
    rst = 1'b0;
    step(2);

    // Steady 4-sample averaging at 100-cycle period.
    dly[0] = 40;
    spacing[0] = P;
    for (int i = 0; i < 4; i++) begin
      p.x = 10'(100 + 4 * i);
      p.y = 10'd1023;
      push_s(0, p);
    end
    p.x = 10'd106;
    p.y = 10'd1023;
    push_e(0, p);
    enable_on(0);
    wait_drain(0, 600);
    check("a_tcnt0", int'(tc[0]), 0);
    check("a_ovr0", int'(oc[0]), 0);

    // Two samples accumulate, the third is abandoned.
    p.x = 10'd1000;
    p.y = 10'd1000;
    push_s(0, p);
    push_s(0, p);
    p.x = 10'd999;
    push_s(0, p);
    wait_starts(0, 3, 400);
    step(10);
    en[0] = 1'b0;
    sc = starts[0];
    step(150);
    check("idle_no_start", starts[0], sc);
    check("idle_busy", int'(busy[0]), 0);
    check("discard_used", ssize(0), 0);

    // Re-enable must start from cleared sums.
    for (int i = 0; i < 4; i++) begin
      p.x = 10'(200 + i);
      p.y = (i == 3) ? 10'd9 : 10'd8;
      push_s(0, p);
    end
    p.x = 10'd201;
    p.y = 10'd8;
    push_e(0, p);
    enable_on(0);
    wait_drain(0, 600);

    // Silent driver: timeouts, then saturation.
    dly[0] = -1;
    wait_tmo(0, 3, 500);
    check("tcnt_3", int'(tc[0]), 3);
    wait_tmo(0, 297, 30500);
    check("tcnt_sat", int'(tc[0]), 255);
    check("a_ovr_none", int'(oc[0]), 0);

    // Reset in the middle of a conversion.
    wait_starts(0, 1, 200);
    step(5);
    check("busy_mid", int'(busy[0]), 1);
    rst = 1'b1;
    en[0] = 1'b0;
    step(1);
    check_rst(0, "rst_mid");
    rst = 1'b0;
    step(2);

    // AVG_LOG2=0: slow driver (overruns), then fast.
    for (int ph = 0; ph < 2; ph++) begin
      dly[1] = tbl[ph * 4].dly;
      spacing[1] = tbl[ph * 4].spc;
      oc0 = int'(oc[1]);
      for (int i = 0; i < 4; i++) begin
        p.x = tbl[ph * 4 + i].x;
        p.y = tbl[ph * 4 + i].y;
        push_s(1, p);
        p.x = tbl[ph * 4 + i].ex;
        p.y = tbl[ph * 4 + i].ey;
        push_e(1, p);
      end
      enable_on(1);
      wait_drain(1, 1500);
      en[1] = 1'b0;
      check($sformatf("b_ovr_ph%0d", ph),
            int'(oc[1]) - oc0, (ph == 0) ? 4 : 0);
      check($sformatf("b_tcnt_ph%0d", ph),
            int'(tc[1]), 0);
      step(5);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
